// File: rtl/spi_sevenseg_frame_tx_pkg.sv
// Shared definitions for the seven-segment SPI frame transmitter: command
// encodings, frame geometry and the transmit FSM state type.
package spi_sevenseg_frame_tx_pkg;

  localparam logic [1:0] CMD_SHOW    = 2'b10;
  localparam logic [1:0] CMD_SHOW_DP = 2'b01;
  localparam logic [1:0] CMD_BLANK   = 2'b00;

  localparam int FRAME_BITS = 6;

  typedef logic [FRAME_BITS-1:0] frame_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

  // The slave expects the command field ahead of the digit, MSB first.
  function automatic frame_t pack_frame(input logic [1:0] cmd, input logic [3:0] data);
    return {cmd, data};
  endfunction

endpackage

// File: rtl/spi_sevenseg_frame_tx_if.sv
// Command input channel of the frame transmitter.
// A command transfers on every sclk edge where in_valid && in_ready; the
// master holds in_cmd/in_data stable while in_valid is high and not accepted,
// and in_ready never depends on in_valid.
interface spi_sevenseg_frame_tx_if;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_cmd;
  logic [3:0] in_data;

  modport master (
    output in_valid,
    output in_cmd,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_cmd,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/spi_sevenseg_frame_tx_fifo.sv
// Synchronous show-ahead FIFO holding queued display commands.
// Pointers carry one extra wrap bit so full and empty are told apart exactly.
module spi_frame_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = (wptr_q == rptr_q);

  // A push is refused when full even if a pop frees a slot on the same edge.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + PW'(1);
    if (do_pop)  rptr_d = rptr_q + PW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/spi_sevenseg_frame_tx.sv
// Buffers display commands and shifts each out as a 6-bit MSB-first frame
// under an active-low slave select, with a minimum idle gap between frames.
module spi_sevenseg_frame_tx
  import spi_sevenseg_frame_tx_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic                          sclk,
  input  logic                          rst_n,
  spi_sevenseg_frame_tx_if.slave        cmd_if,
  output logic                          mosi,
  output logic                          ss,
  output logic                          busy,
  output logic                          frame_done,
  output logic [7:0]                    frame_count,
  output state_e                        state_o
);

  localparam logic [2:0] LAST_BIT = 3'(FRAME_BITS - 1);
  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

  state_e     state_q;
  frame_t     shreg_q;
  logic [2:0] bit_cnt_q;
  logic [3:0] gap_cnt_q;
  logic       mosi_q, ss_q, frame_done_q;
  logic [7:0] frame_count_q;

  logic   fifo_full, fifo_empty;
  frame_t fifo_head;
  logic   push, start_ok, pop;

  assign cmd_if.in_ready = !fifo_full;
  assign push            = cmd_if.in_valid && !fifo_full;

  // A frame may start from IDLE, or straight out of GAP once the gap expires.
  assign start_ok = (state_q == IDLE) || ((state_q == GAP) && (gap_cnt_q == '0));
  assign pop      = start_ok && !fifo_empty;

  spi_frame_fifo #(
    .WIDTH (FRAME_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (sclk),
    .rst_ni  (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (pack_frame(cmd_if.in_cmd, cmd_if.in_data)),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      shreg_q       <= '0;
      bit_cnt_q     <= '0;
      gap_cnt_q     <= '0;
      mosi_q        <= 1'b0;
      ss_q          <= 1'b1;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      frame_done_q <= 1'b0;
      if (pop) begin
        state_q   <= SHIFT;
        shreg_q   <= fifo_head;
        mosi_q    <= fifo_head[FRAME_BITS-1];
        ss_q      <= 1'b0;
        bit_cnt_q <= '0;
      end else begin
        unique case (state_q)
          SHIFT: begin
            if (bit_cnt_q == LAST_BIT) begin
              state_q       <= GAP;
              ss_q          <= 1'b1;
              mosi_q        <= 1'b0;
              frame_done_q  <= 1'b1;
              frame_count_q <= frame_count_q + 8'd1;
              gap_cnt_q     <= GAP_LOAD;
            end else begin
              // shreg[5] already went out at frame start; feed the next bit down.
              bit_cnt_q <= bit_cnt_q + 3'd1;
              mosi_q    <= shreg_q[FRAME_BITS-2];
              shreg_q   <= shreg_q << 1;
            end
          end
          GAP: begin
            if (gap_cnt_q == '0) state_q <= IDLE;
            else                 gap_cnt_q <= gap_cnt_q - 4'd1;
          end
          default: begin
            state_q <= IDLE;
            ss_q    <= 1'b1;
            mosi_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign mosi        = mosi_q;
  assign ss          = ss_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;
  assign busy        = (state_q != IDLE) || !fifo_empty;
  assign state_o     = state_q;

endmodule

// File: doc/spi_sevenseg_frame_tx.md
# spi_sevenseg_frame_tx

SPI frame transmitter that sits directly upstream of the SPI seven-segment display slave. It accepts display commands (2-bit command + 4-bit hex digit) over a valid/ready interface and buffers them in a small FIFO. It then serialises each one as a 6-bit, MSB-first frame on mosi, framed by an active-low ss. The whole block runs in the sclk domain, so the slave samples on the same clock edge that this block drives.

## Interface
- FIFO_DEPTH, 4: command FIFO entries; power of two, 2..16.
- GAP_CYCLES, 1: minimum sclk cycles ss stays high between frames; 1..15.
- sclk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  command present on in_cmd/in_data.
- in_ready  out  1  FIFO can accept; equals !full.
- in_cmd  in  2  command field: 10 = show digit, 01 = show digit with decimal point; 00/11 are sent unchanged.
- in_data  in  4  hex digit 0x0..0xF.
- mosi  out  1  serial data, MSB first.
- ss  out  1  slave select, active-low.
- busy  out  1  high when FSM is not IDLE or FIFO is not empty.
- frame_done  out  1  one-cycle pulse on the edge ss returns high.
- frame_count  out  8  frames completed, wraps at 255 -> 0.

## Operation
- Reset (rst_n=0 at an edge): ss=1, mosi=0, frame_done=0, frame_count=0, FIFO emptied, FSM=IDLE. After reset: in_ready=1, busy=0.
- Push: an edge with in_valid && in_ready writes {in_cmd, in_data} (6 bits) to the FIFO. Values are sampled only when accepted.
- in_ready is combinational from FIFO full only. There is no push when full, even if a pop happens on the same edge.
- A push and a pop on the same edge are both honoured when not full; occupancy is unchanged.
- FSM states are IDLE, SHIFT and GAP.
- IDLE: ss=1, mosi=0. At an edge with FIFO non-empty:
  - pop the head into a 6-bit shift register;
  - drive ss=0 and mosi=bit5;
  - bit counter=0; go to SHIFT.
- SHIFT: each edge advances the bit counter and drives the next bit (bit4..bit0).
  - At the edge where the counter is 5 (bit0 already driven): ss=1, mosi=0, frame_done=1, frame_count+1, go to GAP with gap counter=GAP_CYCLES-1.
- GAP: ss=1. Each edge decrements the gap counter. At counter 0:
  - if the FIFO is non-empty, start the next frame directly (same actions as IDLE start);
  - otherwise go to IDLE.
  - With GAP_CYCLES=1 the GAP state lasts one cycle.
- mosi is 0 whenever ss=1.
- A frame in progress is never aborted except by reset.
- Reset mid-frame: at that edge ss returns to 1 and the frame is truncated. The FIFO contents are discarded and frame_count is cleared.

## Timing
- Frame start edge E0: ss falls and mosi=b5.
- Edges E0..E5: mosi holds b5..b0 respectively. The consumer samples ss=0 at edges E1..E6, exactly 6 bits.
- E6: ss rises and frame_done pulses for one cycle.
- Frame period: 6 + GAP_CYCLES cycles when back-to-back (7 with defaults).
- Push-to-ss-fall latency into an empty, idle block is 1 edge: push at edge P, ss low after edge P+1.
- Sustained throughput is one frame per 6+GAP_CYCLES cycles. The FIFO absorbs bursts of up to FIFO_DEPTH.
- busy deasserts after the GAP state completes with the FIFO empty.

## Structure
- Shared package holds:
  - CMD_SHOW=2'b10, CMD_SHOW_DP=2'b01, CMD_BLANK=2'b00 (blank/malformed);
  - FRAME_BITS=6;
  - the FSM state enum {IDLE, SHIFT, GAP}.
- Sub-module spi_frame_fifo: synchronous FIFO parameterised by width and depth.
  - Pointers are one bit wider than the address.
  - Outputs full, empty and head data (show-ahead).
- The top level holds the FSM, shift register, bit/gap counters and frame_count.

## Test plan
- Reset with in_valid held high -> in_ready=1, ss=1, mosi=0, frame_count=0, no push during reset.
- Single push {10, 0x5} into idle block -> ss low for 6 cycles, mosi 1,0,0,1,0,1 on E0..E5, frame_done at E6, frame_count=1.
- Burst of 6 pushes with FIFO_DEPTH=4:
  - in_ready drops after 4 outstanding, only while full;
  - all 6 frames are sent in order 0x0..0x5 with cmd 01;
  - ss-high gap is exactly 1 cycle between frames.
- GAP_CYCLES=3, two queued frames -> ss high exactly 3 cycles between them.
- Reset asserted at E3 of a frame with 2 queued -> ss=1 next edge, FIFO empty, busy=0, no further frames.
- Push {11, 0xF} -> sent unchanged (111111).
- 256 frames -> frame_count wraps to 0.
